instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning instruction memory size in 32-bit words (power of two, 4..256).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load_start  input  1  pulse: begin (re)loading program from word 0.
REQ-005 SHALL have port load_end  input  1  pulse: terminate load, release core.
REQ-006 SHALL have port byte_in  input  8  program byte, little-endian within each word.
REQ-007 SHALL have port byte_valid  input  1  byte_in holds a byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port addr  input  32  core fetch address (byte address).
REQ-010 SHALL have port instr  output  32  instruction returned to core.
REQ-011 SHALL have port core_rst  output  1  holds core in reset while not running.
REQ-012 SHALL have port word_count  output  $clog2(DEPTH)+1  number of complete words written since last load_start.
REQ-013 SHALL have port checksum  output  8  running byte checksum (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-015 IDLE -> LOAD on load_start; RUN -> LOAD on load_start; LOAD -> LOAD on load_start restarts byte_cnt, word_ptr, word_count, checksum to 0.
REQ-016 LOAD -> RUN on load_end, or on the cycle the byte completing word DEPTH-1 is accepted; load_start takes priority over load_end in the same cycle.
REQ-017 byte_ready SHALL be 1 exactly when state is LOAD; a byte is accepted when byte_valid && byte_ready.
REQ-018 Accepted bytes SHALL fill a 32-bit assembly register at lane byte_cnt (byte 0 -> bits 7:0); byte_cnt 2-bit counter wraps 3 -> 0.
REQ-019 On the 4th accepted byte the assembled word (including that byte) SHALL be written to mem[word_ptr] the same edge; word_ptr and word_count increment.
REQ-020 byte_valid and load_end in the same LOAD cycle: byte SHALL be accepted (and word written if completed) before transition to RUN.
REQ-021 On load_end, a partial word (byte_cnt != 0) SHALL be discarded; unwritten words keep prior contents.
REQ-022 Bytes presented in IDLE or RUN SHALL be ignored.
REQ-023 core_rst SHALL be 1 in IDLE and LOAD, 0 in RUN (registered from state, no extra latency).
REQ-024 instr SHALL be combinational: mem[addr[$clog2(DEPTH)+1:2]] when addr < 4*DEPTH, else 32'h00000013 (NOP); addr[1:0] ignored.
REQ-025 A write and a read of the same word in one cycle SHALL return the old contents (no bypass).

Reset
REQ-026 On rst: state IDLE, byte_cnt 0, word_ptr 0, word_count 0, checksum 0, assembly register 0, all mem words 32'h00000013.
REQ-027 Reset outputs: byte_ready 0, core_rst 1; instr = NOP for any addr.
REQ-028 rst asserted mid-LOAD SHALL abort immediately; partial data lost, memory reinitialised.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN: when defined, checksum SHALL accumulate modulo-256 sum of every accepted byte since last load_start/reset.
REQ-030 When LOADER_CHECKSUM_EN is undefined, checksum SHALL be constant 0 and no accumulator logic exists.

Verification
REQ-031 Reset, addr=0 -> instr=32'h00000013, core_rst=1, byte_ready=0.
REQ-032 load_start, bytes 93,00,A0,00 (one per cycle), load_end -> mem[0]=32'h00A00093, word_count=1, core_rst=0 next cycle, instr@addr 0 = 32'h00A00093.
REQ-033 Load 4*DEPTH bytes with no load_end -> auto RUN after last byte, word_count=DEPTH, byte_ready falls same edge.
REQ-034 load_start, 6 bytes, load_end -> word_count=1, mem[1] = NOP, checksum = sum of 6 bytes mod 256 (with macro) or 0 (without).
REQ-035 Byte completing word 0 coincident with load_end -> word written, RUN entered; addr=4*DEPTH -> NOP.
REQ-036 rst pulse after 2 accepted bytes -> state IDLE, word_count 0, instr@0 = NOP.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: load stream, core fetch and status signals between the program source/core and the loader.
interface instr_mem_loader_if #(parameter int DEPTH = 16);
  logic                     load_start;
  logic                     load_end;
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic [31:0]              addr;
  logic [31:0]              instr;
  logic                     core_rst;
  logic [$clog2(DEPTH):0]   word_count;
  logic [7:0]               checksum;
  modport master (
    output load_start, load_end, byte_in, byte_valid, addr,
    input  byte_ready, instr, core_rst, word_count, checksum
  );
  modport slave (
    input  load_start, load_end, byte_in, byte_valid, addr,
    output byte_ready, instr, core_rst, word_count, checksum
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a little-endian byte stream into instruction memory and holds the core in reset until loaded.
// Optional running byte checksum enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int DEPTH = 16
) (
  input logic              clk,
  input logic              rst,
  instr_mem_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_ptr_q, word_ptr_d;
  logic [AW:0]   word_count_q, word_count_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   mem_q [DEPTH];
  logic          accept, we;
  // load_start wins over everything: a byte offered in the same cycle is dropped
  always_comb begin
    state_d = state_q;
    accept = state_q == LOAD && bus.byte_valid && !bus.load_start;
    we = accept && byte_cnt_q == 2'd3;
    asm_d = asm_q;
    if (accept) asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_in;
    byte_cnt_d = accept ? byte_cnt_q + 2'd1 : byte_cnt_q;
    word_ptr_d = we ? word_ptr_q + AW'(1) : word_ptr_q;
    word_count_d = we ? word_count_q + (AW+1)'(1) : word_count_q;
    if (bus.load_start) begin
      state_d = LOAD;
      byte_cnt_d = '0;
      word_ptr_d = '0;
      word_count_d = '0;
      asm_d = '0;
    end else if (state_q == LOAD && (bus.load_end || (we && word_ptr_q == AW'(DEPTH - 1)))) begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      byte_cnt_q <= '0;
      word_ptr_q <= '0;
      word_count_q <= '0;
      asm_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP;
    end else begin
      state_q <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_ptr_q <= word_ptr_d;
      word_count_q <= word_count_d;
      asm_q <= asm_d;
      if (we) mem_q[word_ptr_q] <= asm_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  always_comb sum_d = bus.load_start ? 8'h00 : accept ? sum_q + bus.byte_in : sum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign bus.checksum = sum_q;
`else
  assign bus.checksum = 8'h00;
`endif
  assign bus.byte_ready = state_q == LOAD;
  assign bus.core_rst = state_q != RUN;
  assign bus.word_count = word_count_q;
  // fetch reads the registered array directly, so a same-cycle write returns old contents
  assign bus.instr = bus.addr < 32'(4 * DEPTH) ? mem_q[bus.addr[AW+1:2]] : NOP;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed vectors for instr_mem_loader with hand-computed expectations.
module tb_instr_mem_loader;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_bad = 0;
  instr_mem_loader_if #(.DEPTH(DEPTH)) bus ();
  instr_mem_loader #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1;
    bus.byte_in = b;
    tick();
    bus.byte_valid = 0;
  endtask
  task automatic pulse_start;
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
  endtask
  task automatic pulse_end;
    bus.load_end = 1;
    tick();
    bus.load_end = 0;
  endtask
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.instr, exp);
  endtask
  function automatic logic [7:0] pb(input int k);
    return 8'(k * 7 + 3);
  endfunction
  function automatic logic [31:0] pw(input int w);
    return {pb(4*w+3), pb(4*w+2), pb(4*w+1), pb(4*w)};
  endfunction
  logic [7:0] exp_sum;
  initial begin
    bus.load_start = 0;
    bus.load_end = 0;
    bus.byte_in = 0;
    bus.byte_valid = 0;
    bus.addr = 0;
    tick();
    tick();
    fetch("rst_instr0", 0, NOP);
    check("rst_core_rst", bus.core_rst, 1);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_word_count", bus.word_count, 0);
    check("rst_checksum", bus.checksum, 0);
    rst = 0;
    tick();
    send(8'h55);
    check("idle_ignore", bus.word_count, 0);
    pulse_start();
    check("load_ready", bus.byte_ready, 1);
    check("load_core_rst", bus.core_rst, 1);
    send(8'h93); send(8'h00); send(8'hA0); send(8'h00);
    check("w0_count", bus.word_count, 1);
    pulse_end();
    check("w0_core_rst", bus.core_rst, 0);
    check("w0_ready", bus.byte_ready, 0);
    fetch("w0_instr", 0, 32'h00A00093);
    fetch("w0_instr4", 4, NOP);
    pulse_start();
    check("reload_count", bus.word_count, 0);
    for (int k = 0; k < 4 * DEPTH; k++) begin
      if (k == 4 * DEPTH - 1) check("full_ready_pre", bus.byte_ready, 1);
      send(pb(k));
    end
    check("full_ready_post", bus.byte_ready, 0);
    check("full_core_rst", bus.core_rst, 0);
    check("full_count", bus.word_count, DEPTH);
    fetch("full_w0", 0, pw(0));
    fetch("full_w5", 21, pw(5));
    fetch("full_wlast", 4 * DEPTH - 4, pw(DEPTH - 1));
    fetch("full_oob", 4 * DEPTH, NOP);
    send(8'hEE);
    check("run_ignore", bus.word_count, DEPTH);
    fetch("run_ignore_w0", 0, pw(0));
    rst = 1;
    tick();
    rst = 0;
    tick();
    pulse_start();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    pulse_end();
    check("part_count", bus.word_count, 1);
    fetch("part_w0", 0, 32'h44332211);
    fetch("part_w1", 4, NOP);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 8'h65;
`else
    exp_sum = 8'h00;
`endif
    check("part_checksum", bus.checksum, exp_sum);
    pulse_start();
    send(8'hAA); send(8'hBB); send(8'hCC);
    bus.load_end = 1;
    send(8'hDD);
    bus.load_end = 0;
    check("coinc_count", bus.word_count, 1);
    check("coinc_core_rst", bus.core_rst, 0);
    fetch("coinc_w0", 0, 32'hDDCCBBAA);
    fetch("coinc_oob", 4 * DEPTH, NOP);
    pulse_start();
    bus.load_start = 1;
    bus.load_end = 1;
    tick();
    bus.load_start = 0;
    bus.load_end = 0;
    check("prio_ready", bus.byte_ready, 1);
    send(8'h01); send(8'h02);
    #2 rst = 1;
    #2 rst = 0;
    check("arst_core_rst", bus.core_rst, 1);
    check("arst_ready", bus.byte_ready, 0);
    check("arst_count", bus.word_count, 0);
    fetch("arst_instr0", 0, NOP);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
